stream_mux_n_1: RTL and testbench

Parametrised successor to the 2:1 mux: an N-input, WIDTH-bit registered stream multiplexer with per-channel valid/ready handshake. Two selection modes are supported: fixed select, or round-robin arbitration across valid channels. One output register stage carries the data together with a source-channel tag and a free-running accepted-beat counter. The block sits between several producer streams and a single consumer.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/stream_mux_n_1.sv | 125 ++++++++++++
 tb/tb_stream_mux_n_1.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 registered stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width, never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the channel after
// `last` sits at bit 0, pick the lowest set bit, then rotate the index back.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_vld,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [2*N-1:0] req2_s;
  logic [N-1:0]   rot_s;
  int             start_s;
  int             off_s;

  // Rotate / priority-encode / unrotate.
  always_comb begin
    start_s = (int'(last) + 32'sd1) % N;
    req2_s  = {req, req};
    rot_s   = N'(req2_s >> start_s);
    off_s   = 32'sd0;
    for (int k = N - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? k : off_s;
    end
    gnt_vld = |req;
    gnt_idx = SEL_W'((start_s + off_s) % N);
  end

endmodule

// File: rtl/stream_mux_n_1.sv
// N-input registered stream multiplexer with fixed-select or round-robin
// arbitration, source-channel tag and a wrapping accepted-beat counter.
module stream_mux_n_1
  import stream_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = sel_width(N),
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   beat_count
);

  logic             load_en_s;
  logic             xfer_s;
  logic             grant_vld_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             rr_vld_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic [SEL_W-1:0] last_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_ch_r;
  logic [CNT_W-1:0] beat_count_r;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req     (in_valid),
    .last    (last_r),
    .gnt_vld (rr_vld_s),
    .gnt_idx (rr_idx_s)
  );

  // Grant selection; an out-of-range sel grants nothing.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = {SEL_W{1'b0}};
    case (mode)
      MODE_FIXED: begin
        if (int'(sel) < N) begin
          grant_vld_s = in_valid[sel];
          grant_idx_s = sel;
        end else begin
          grant_vld_s = 1'b0;
          grant_idx_s = {SEL_W{1'b0}};
        end
      end
      MODE_RR: begin
        grant_vld_s = rr_vld_s;
        grant_idx_s = rr_idx_s;
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_idx_s = {SEL_W{1'b0}};
      end
    endcase
  end

  // Handshake: the register refills in the same cycle it drains.
  always_comb begin
    load_en_s = ~out_valid_r | out_ready;
    xfer_s    = load_en_s & grant_vld_s;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer_s & (int'(grant_idx_s) == i);
    end
  end

  // Data of the granted channel.
  always_comb begin
    grant_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      grant_data_s = (int'(grant_idx_s) == i) ? in_data[i*WIDTH +: WIDTH] : grant_data_s;
    end
  end

  // Output register stage and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {WIDTH{1'b0}};
      out_ch_r     <= {SEL_W{1'b0}};
      beat_count_r <= {CNT_W{1'b0}};
    end else if (xfer_s) begin
      out_valid_r  <= 1'b1;
      out_data_r   <= grant_data_s;
      out_ch_r     <= grant_idx_s;
      beat_count_r <= beat_count_r + CNT_W'(1'b1);
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  // Round-robin pointer moves only on round-robin transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= SEL_W'(N - 1);
    end else if (xfer_s && (mode == MODE_RR)) begin
      last_r <= grant_idx_s;
    end else begin
      last_r <= last_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_ch     = out_ch_r;
  assign beat_count = beat_count_r;

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Bench for stream_mux_n_1: directed scenarios plus randomized traffic
// checked against a behavioural model of the multiplexer.
module tb_stream_mux_n_1;

  localparam int N = 4, WIDTH = 8, SEL_W = 2, CNT_W = 16;
  localparam int N3 = 3, SEL_W3 = 2, CNT_W3 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_ch;
  logic               out_ready;
  logic [CNT_W-1:0]   beat_count;

  logic                mode3;
  logic [SEL_W3-1:0]   sel3;
  logic [N3-1:0]       in_valid3;
  logic [N3*WIDTH-1:0] in_data3;
  logic [N3-1:0]       in_ready3;
  logic                out_valid3;
  logic [WIDTH-1:0]    out_data3;
  logic [SEL_W3-1:0]   out_ch3;
  logic                out_ready3;
  logic [CNT_W3-1:0]   beat_count3;

  int total = 0;
  int passed = 0;
  int fails = 0;

  // Reference model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_cnt;
  int         m_last;

  always #5 clk = ~clk;

  stream_mux_n_1 #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
    .beat_count(beat_count)
  );

  stream_mux_n_1 #(.N(N3), .WIDTH(WIDTH), .SEL_W(SEL_W3), .CNT_W(CNT_W3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_valid(in_valid3),
    .in_data(in_data3), .in_ready(in_ready3), .out_valid(out_valid3),
    .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3),
    .beat_count(beat_count3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_cnt   = 0;
    m_last  = N - 1;
  endtask

  // Which channel the rules grant this cycle, if any.
  task automatic ref_grant(output bit gv, output int gi);
    int c;
    gv = 1'b0;
    gi = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin
        gv = 1'b1;
        gi = int'(sel);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          gi = c;
        end
      end
    end
  endtask

  // One clock: check in_ready mid-cycle, advance model at the edge, check outputs.
  task automatic cycle(input string tag);
    bit         gv;
    int         gi;
    bit         load;
    logic [N-1:0] er;
    @(negedge clk);
    ref_grant(gv, gi);
    load = !m_valid || out_ready;
    er = 4'b0000;
    if (load && gv) er[gi] = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    if (load && gv) begin
      m_valid = 1'b1;
      m_data  = in_data[gi*WIDTH +: WIDTH];
      m_ch    = gi;
      m_cnt   = (m_cnt + 1) % 65536;
      if (mode) m_last = gi;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    check({tag, ".out_ch"}, 32'(out_ch), 32'(m_ch));
    check({tag, ".beat_count"}, 32'(beat_count), 32'(m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    mode3 = 1'b1; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = 24'hC2C1C0; out_ready3 = 1'b1;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.out_ch", 32'(out_ch), 32'd0);
    check("rst.beat_count", 32'(beat_count), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'b0001);
    #3 rst = 1'b0;

    // Round-robin, all channels valid: 0,1,2,3,0 with no bubbles
    for (int k = 0; k < 5; k++) begin
      cycle("rr_all");
      check("rr_all.seq_ch", 32'(out_ch), 32'(k % 4));
      check("rr_all.seq_data", 32'(out_data), 32'(8'hA0 + k % 4));
    end

    // Fixed select on channel 2
    mode = 1'b0; sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      cycle("fixed");
      check("fixed.data", 32'(out_data), 32'h0A2);
    end

    // Round-robin sparse, then a single valid channel
    mode = 1'b1; in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle("rr_sparse");
      check("rr_sparse.seq_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
    end
    in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      cycle("rr_single");
      check("rr_single.ch", 32'(out_ch), 32'd1);
    end

    // Backpressure: hold A1 for three cycles, then drain and refill together
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF;
    cycle("bp_load");
    out_ready = 1'b0; sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      cycle("bp_stall");
      check("bp_stall.data", 32'(out_data), 32'h0A1);
      check("bp_stall.ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_release.data", 32'(out_data), 32'h0A2);

    // Drain without refill
    in_valid = 4'h0;
    cycle("drain");

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    // Async reset between edges with a beat held
    mode = 1'b1; in_valid = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b0;
    cycle("pre_rst");
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.beat_count", 32'(beat_count), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    cycle("post_rst");
    check("post_rst.first_ch", 32'(out_ch), 32'd0);
    in_valid = 4'h0;

    // 3-channel, 4-bit counter build: counter wraps after 16 beats
    in_valid3 = 3'b111;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check("wrap.ch", 32'(out_ch3), 32'((k - 1) % 3));
      check("wrap.data", 32'(out_data3), 32'(8'hC0 + (k - 1) % 3));
      check("wrap.count", 32'(beat_count3), 32'(k % 16));
    end

    // Out-of-range select grants nothing; held beat drains
    mode3 = 1'b0; sel3 = 2'd3;
    @(negedge clk);
    check("badsel.in_ready", 32'(in_ready3), 32'd0);
    @(posedge clk);
    #1;
    check("badsel.out_valid", 32'(out_valid3), 32'd0);
    check("badsel.count", 32'(beat_count3), 32'd0);
    sel3 = 2'd1;
    @(negedge clk);
    check("sel1.in_ready", 32'(in_ready3), 32'b010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
